// File: rtl/tff_async.sv
// -----------------------------------------------------------------------------
// tff_async
//
// Bank of independent toggle flip-flops with a synchronous, active-high clear.
// Each bit of Q inverts on a rising CLK edge when its t bit is high, and holds
// when its t bit is low. A CLEAR sampled high loads RESET_VALUE and ignores t.
//
// No initial value is applied. Q is X until the first edge that samples
// CLEAR = 1, so the surrounding logic must assert CLEAR before it uses Q.
//
// Parameters:
//   WIDTH        number of independent toggle bits (default 1)
//   RESET_VALUE  value loaded into Q by CLEAR (default all zeros)
//
// Ports (this order is fixed because instantiations are positional):
//   t      in   WIDTH  per-bit toggle request
//   CLK    in   1      clock; all state changes on the rising edge
//   CLEAR  in   1      synchronous active-high clear
//   Q      out  WIDTH  registered toggle state
//   Qn     out  WIDTH  ~Q, present only when TFF_ASYNC_QN_EN is defined
//
// Optional feature macro: TFF_ASYNC_QN_EN
//   Defined     : adds the Qn port, decoded from the same register as Q.
//   Not defined : the module has exactly the four ports t, CLK, CLEAR, Q.
// -----------------------------------------------------------------------------
module tff_async #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic [WIDTH-1:0] t,
    input  logic             CLK,
    input  logic             CLEAR,
    output logic [WIDTH-1:0] Q
`ifdef TFF_ASYNC_QN_EN
    ,
    output logic [WIDTH-1:0] Qn
`endif
);

    // Clear has priority over toggling. Q comes straight from these flops,
    // so there is no combinational path from any input to Q.
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= Q ^ t;
        end
    end

`ifdef TFF_ASYNC_QN_EN
    // Complement is a plain inversion of the state register, with no second
    // flop, so it stays X until the first clear just like Q.
    assign Qn = ~Q;
`endif

endmodule

// File: tb/tb_tff_async.sv
// -----------------------------------------------------------------------------
// tb_tff_async
//
// Directed, table-driven bench for tff_async. Two instances are used: a
// default one (WIDTH=1, RESET_VALUE=0) and a vector one (WIDTH=4,
// RESET_VALUE=4'b1010). Inputs change on the falling edge; outputs are
// sampled 1 ns after the rising edge. A few hand-written sequences cover the
// "changes between edges have no effect" cases.
// -----------------------------------------------------------------------------
module tb_tff_async;

    // ---------------- clock / reset block ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [0:0] t1;
    logic       clear1;
    logic [0:0] q1;
    logic [3:0] t4;
    logic       clear4;
    logic [3:0] q4;
`ifdef TFF_ASYNC_QN_EN
    logic [0:0] qn1;
    logic [3:0] qn4;
`endif

    tff_async u_dut1 (
        .t     (t1),
        .CLK   (clk),
        .CLEAR (clear1),
        .Q     (q1)
`ifdef TFF_ASYNC_QN_EN
        ,
        .Qn    (qn1)
`endif
    );

    tff_async #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1010)
    ) u_dut4 (
        .t     (t4),
        .CLK   (clk),
        .CLEAR (clear4),
        .Q     (q4)
`ifdef TFF_ASYNC_QN_EN
        ,
        .Qn    (qn4)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic       clear;
        logic [0:0] t;
        logic [0:0] exp_q;
    } vec1_t;

    typedef struct {
        logic       clear;
        logic [3:0] t;
        logic [3:0] exp_q;
    } vec4_t;

    localparam int N1 = 16;
    localparam int N4 = 7;
    vec1_t tab1[N1];
    vec4_t tab4[N4];

    // ---------------- driver tasks ----------------
    task automatic drive1(input logic clear, input logic [0:0] t);
        @(negedge clk);
        clear1 = clear;
        t1     = t;
    endtask

    task automatic drive4(input logic clear, input logic [3:0] t);
        @(negedge clk);
        clear4 = clear;
        t4     = t;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_q1(input string name, input logic [0:0] exp);
        check(name, {3'b000, q1}, {3'b000, exp});
`ifdef TFF_ASYNC_QN_EN
        check({name, "_qn"}, {3'b000, qn1}, {3'b000, ~exp});
`endif
    endtask

    task automatic check_q4(input string name, input logic [3:0] exp);
        check(name, q4, exp);
`ifdef TFF_ASYNC_QN_EN
        check({name, "_qn"}, qn4, ~exp);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        t1     = 1'b0;
        clear1 = 1'b0;
        t4     = 4'b0000;
        clear4 = 1'b0;

        // WIDTH=1 table: reset with t high, toggle run, hold, clear priority,
        // held clear, release.
        tab1[0]  = '{1'b1, 1'b1, 1'b0};  // reset edge 1, t ignored
        tab1[1]  = '{1'b1, 1'b1, 1'b0};  // reset edge 2
        tab1[2]  = '{1'b0, 1'b1, 1'b1};  // toggle 1
        tab1[3]  = '{1'b0, 1'b1, 1'b0};  // toggle 2
        tab1[4]  = '{1'b0, 1'b1, 1'b1};  // toggle 3
        tab1[5]  = '{1'b0, 1'b1, 1'b0};  // toggle 4
        tab1[6]  = '{1'b0, 1'b1, 1'b1};  // back to 1
        tab1[7]  = '{1'b0, 1'b0, 1'b1};  // hold
        tab1[8]  = '{1'b0, 1'b0, 1'b1};  // hold
        tab1[9]  = '{1'b0, 1'b0, 1'b1};  // hold
        tab1[10] = '{1'b0, 1'b1, 1'b0};  // single toggle
        tab1[11] = '{1'b0, 1'b1, 1'b1};  // Q=1 again
        tab1[12] = '{1'b1, 1'b1, 1'b0};  // clear beats toggle from Q=1
        tab1[13] = '{1'b1, 1'b0, 1'b0};  // clear held
        tab1[14] = '{1'b0, 1'b1, 1'b1};  // toggling resumes on first release edge
        tab1[15] = '{1'b0, 1'b0, 1'b1};  // hold

        // WIDTH=4, RESET_VALUE=1010.
        tab4[0] = '{1'b1, 4'b0000, 4'b1010};
        tab4[1] = '{1'b0, 4'b0011, 4'b1001};
        tab4[2] = '{1'b0, 4'b1111, 4'b0110};
        tab4[3] = '{1'b0, 4'b0000, 4'b0110};
        tab4[4] = '{1'b0, 4'b1000, 4'b1110};
        tab4[5] = '{1'b1, 4'b1111, 4'b1010};
        tab4[6] = '{1'b0, 4'b0101, 4'b1111};

        for (int i = 0; i < N1; i++) begin
            drive1(tab1[i].clear, tab1[i].t);
            after_edge();
            check_q1($sformatf("w1_vec%0d", i), tab1[i].exp_q);
        end

        for (int i = 0; i < N4; i++) begin
            drive4(tab4[i].clear, tab4[i].t);
            after_edge();
            check_q4($sformatf("w4_vec%0d", i), tab4[i].exp_q);
        end

        // Hand sequence: Q1 is 1 here. CLEAR pulsed between edges and dropped
        // again before the edge must leave Q alone.
        drive1(1'b0, 1'b0);
        #1 clear1 = 1'b1;
        #1;
        check_q1("mid_clear_no_async", 1'b1);
        #1 clear1 = 1'b0;
        after_edge();
        check_q1("mid_clear_dropped", 1'b1);

        // CLEAR raised mid-cycle with t high: no change until the edge, then
        // clear wins over the toggle.
        drive1(1'b0, 1'b1);
        #2 clear1 = 1'b1;
        #1;
        check_q1("mid_clear_before_edge", 1'b1);
        after_edge();
        check_q1("mid_clear_at_edge", 1'b0);

        // t changing between edges has no effect until the next edge.
        drive1(1'b0, 1'b1);
        #2 t1 = 1'b0;
        #1;
        check_q1("t_glitch_between_edges", 1'b0);
        after_edge();
        check_q1("t_low_at_edge", 1'b0);

        // Continuous t: square wave at fCLK/2.
        drive1(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            after_edge();
            check_q1($sformatf("square_%0d", i), (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound in case the clock stops advancing the stimulus.
    initial begin
        #100000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tff_async.md
# tff_async

Toggle flip-flop bank with synchronous clear, used wherever the design needs a divide-by-two or parity/toggle state element. On each rising clock edge every bit of `Q` inverts when its `t` bit is high and holds when it is low. An active-high synchronous `CLEAR` forces `Q` to a configurable reset value. Instantiations are positional, so the port order below is mandatory.

## Interface
- `WIDTH`, default 1: number of independent toggle bits.
- `RESET_VALUE`, default all zeros (`{WIDTH{1'b0}}`): value loaded into `Q` by `CLEAR`.
- Port declaration order: `t`, `CLK`, `CLEAR`, `Q`.
- `CLK`  input  1: single clock; all state changes on the rising edge.
- `CLEAR`  input  1: reset, synchronous and active-high; sampled on the `CLK` rising edge.
- `t`  input  WIDTH: per-bit toggle request.
- `Q`  output  WIDTH: registered flip-flop state.

## Operation
- On each `CLK` rising edge, evaluated in priority order:
  - `CLEAR` = 1: `Q <= RESET_VALUE`. `t` is ignored.
  - Otherwise: `Q <= Q ^ t`. Each bit with `t` = 1 inverts; each bit with `t` = 0 holds.
- Between rising edges, `Q` holds. Changes on `t` or `CLEAR` have no effect until the next rising edge.
- Bits are fully independent; there is no carry or interaction between bits.
- Power-up: no initial value is applied. `Q` is undefined (X in simulation) until the first edge with `CLEAR` = 1. The system must assert `CLEAR` for at least one rising edge before using `Q`.
- No combinational path from any input to `Q`. `Q` is driven directly by the flops.

## Timing
- Latency: 1 cycle. Inputs sampled at edge n appear on `Q` just after edge n.
- `CLEAR` held high across several edges: `Q` stays at `RESET_VALUE` on every one of them.
- `CLEAR` deasserted: toggling resumes at the first edge that samples `CLEAR` = 0.
- `CLEAR` and `t` both high at the same edge: clear wins, and `Q` = `RESET_VALUE`.
- `CLEAR` asserted mid-sequence: takes effect at the next rising edge only, never asynchronously.
- `t` held high continuously: `Q` toggles every cycle, giving a square wave at fCLK/2.
- Inputs must meet setup/hold relative to the `CLK` rising edge. Stimulus must not change on the active edge itself.

## Configuration
- Macro `TFF_ASYNC_QN_EN`.
  - Defined: adds output port `Qn` (WIDTH bits, declared after `Q`), equal to `~Q` at all times. It is derived from the same register, with no extra flops, so it is also X before the first clear.
  - Not defined: no `Qn` port. The module has exactly four ports.

## Test plan
- Reset: `CLEAR`=1, `t`=1 for 2 edges -> `Q`=0 after each edge (WIDTH=1, default `RESET_VALUE`).
- Toggle: after reset, `CLEAR`=0, `t`=1 for 4 edges -> `Q` sequence 1,0,1,0.
- Hold: `Q`=1, `t`=0 for 3 edges -> `Q` stays 1. Raising `t`=1 for one edge -> `Q`=0.
- Clear priority / mid-operation: `Q`=1, `t`=1, `CLEAR`=1 at one edge -> `Q`=0, not a toggle. Changing `CLEAR` between edges does not alter `Q` until the next edge.
- Vector and reset value: WIDTH=4, `RESET_VALUE`=4'b1010, clear -> `Q`=1010. Then `t`=0011 for one edge -> `Q`=1001, and `t`=1111 for one edge -> `Q`=0110.
- With `TFF_ASYNC_QN_EN` defined: repeat the toggle test and check `Qn`=`~Q` after every edge. Without the macro, confirm the build has no `Qn` port.
